// File: rtl/ps2_cmd_ctrl.sv
// ps2_cmd_ctrl: host-side PS/2 command sequencer (byte send, ACK wait, resend/timeout retry, scan forwarding).
// Optional PS2_INIT_EN: after reset, send 0xFF and wait for the 0xAA BAT-pass byte before accepting commands.
module ps2_cmd_ctrl #(
    parameter int            TW        = 20,
    parameter logic [TW-1:0] TIMEOUT   = 20'd500000,
    parameter int            MAX_RETRY = 3
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       cmd_valid_i,
    input  logic       cmd_two_i,
    input  logic [7:0] cmd_byte_i,
    input  logic [7:0] cmd_arg_i,
    output logic       cmd_ready_o,
    output logic       cmd_done_tick_o,
    output logic       cmd_err_tick_o,
    input  logic       tx_idle_i,
    input  logic       tx_done_tick_i,
    output logic       wr_ps2_o,
    output logic [7:0] tx_din_o,
    input  logic       rx_done_tick_i,
    input  logic [7:0] rx_dout_i,
    output logic       rx_en_o,
    output logic       scan_valid_o,
    output logic [7:0] scan_code_o
);

    localparam int            RW         = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TMO_LAST   = TIMEOUT - TW'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        WAIT_TX  = 3'd2,
        WAIT_ACK = 3'd3,
        WAIT_BAT = 3'd4
    } state_t;

    state_t        state_q;
    logic [7:0]    byte0_q;
    logic [7:0]    byte1_q;
    logic          two_q;
    logic          idx_q;
    logic [RW-1:0] retry_q;
    logic [TW-1:0] timer_q;
    logic          cmd_ready_q;
    logic          done_q;
    logic          err_q;
    logic          wr_q;
    logic [7:0]    tx_din_q;
    logic          rx_en_q;
    logic          scan_valid_q;
    logic [7:0]    scan_code_q;

`ifdef PS2_INIT_EN
    localparam int            BW       = TW + 6;
    localparam logic [BW-1:0] BAT_LAST = BW'(50 * TIMEOUT - 1);
    logic          init_q;
    logic [BW-1:0] bat_q;
`endif

    logic       rx_ack;
    logic       rx_nak;
    logic       tmo;
    logic [7:0] cur_byte;

    assign rx_ack   = rx_done_tick_i && (rx_dout_i == 8'hFA);
    assign rx_nak   = rx_done_tick_i && (rx_dout_i == 8'hFE);
    assign tmo      = (timer_q == TMO_LAST);
    assign cur_byte = idx_q ? byte1_q : byte0_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
`ifdef PS2_INIT_EN
            state_q     <= SEND;
            byte0_q     <= 8'hFF;
            cmd_ready_q <= 1'b0;
            rx_en_q     <= 1'b0;
            init_q      <= 1'b1;
            bat_q       <= '0;
`else
            state_q     <= IDLE;
            byte0_q     <= 8'h00;
            cmd_ready_q <= 1'b1;
            rx_en_q     <= 1'b1;
`endif
            byte1_q      <= 8'h00;
            two_q        <= 1'b0;
            idx_q        <= 1'b0;
            retry_q      <= '0;
            timer_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wr_q         <= 1'b0;
            tx_din_q     <= 8'h00;
            scan_valid_q <= 1'b0;
            scan_code_q  <= 8'h00;
        end else begin
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wr_q         <= 1'b0;
            scan_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (rx_done_tick_i) begin
                        scan_valid_q <= 1'b1;
                        scan_code_q  <= rx_dout_i;
                    end
                    if (cmd_valid_i) begin
                        byte0_q     <= cmd_byte_i;
                        byte1_q     <= cmd_arg_i;
                        two_q       <= cmd_two_i;
                        idx_q       <= 1'b0;
                        retry_q     <= '0;
                        cmd_ready_q <= 1'b0;
                        rx_en_q     <= 1'b0;
                        state_q     <= SEND;
                    end
                end

                SEND: begin
                    if (tx_idle_i) begin
                        wr_q     <= 1'b1;
                        tx_din_q <= cur_byte;
                        state_q  <= WAIT_TX;
                    end
                end

                WAIT_TX: begin
                    if (tx_done_tick_i) begin
                        timer_q <= '0;
                        rx_en_q <= 1'b1;
                        state_q <= WAIT_ACK;
                    end
                end

                WAIT_ACK: begin
                    if (!tmo) begin
                        timer_q <= timer_q + TW'(1);
                    end
                    // A received byte takes priority over a timeout in the same cycle.
                    if (rx_ack) begin
                        if (!idx_q && two_q) begin
                            idx_q   <= 1'b1;
                            retry_q <= '0;
                            rx_en_q <= 1'b0;
                            state_q <= SEND;
                        end
`ifdef PS2_INIT_EN
                        else if (init_q) begin
                            bat_q   <= '0;
                            state_q <= WAIT_BAT;
                        end
`endif
                        else begin
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end else if (rx_nak || (!rx_done_tick_i && tmo)) begin
                        if (retry_q == RETRY_LAST) begin
                            err_q       <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state_q     <= IDLE;
`ifdef PS2_INIT_EN
                            init_q      <= 1'b0;
`endif
                        end else begin
                            retry_q <= retry_q + RW'(1);
                            rx_en_q <= 1'b0;
                            state_q <= SEND;
                        end
                    end else if (rx_done_tick_i) begin
                        scan_valid_q <= 1'b1;
                        scan_code_q  <= rx_dout_i;
                    end
                end

`ifdef PS2_INIT_EN
                WAIT_BAT: begin
                    if (bat_q != BAT_LAST) begin
                        bat_q <= bat_q + BW'(1);
                    end
                    // Any byte other than 0xAA is a BAT failure; 0xAA itself is consumed here.
                    if (rx_done_tick_i || (bat_q == BAT_LAST)) begin
                        err_q       <= !(rx_done_tick_i && (rx_dout_i == 8'hAA));
                        cmd_ready_q <= 1'b1;
                        rx_en_q     <= 1'b1;
                        init_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
`endif

                default: begin
                    cmd_ready_q <= 1'b1;
                    rx_en_q     <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o     = cmd_ready_q;
    assign cmd_done_tick_o = done_q;
    assign cmd_err_tick_o  = err_q;
    assign wr_ps2_o        = wr_q;
    assign tx_din_o        = tx_din_q;
    assign rx_en_o         = rx_en_q;
    assign scan_valid_o    = scan_valid_q;
    assign scan_code_o     = scan_code_q;

endmodule
